// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the multiplier arbiter/sequencer.
//   arb_state_t          : sequencer state encoding
//   MUL_WIDTH_DEFAULT    : default operand width
//   MUL_TIMEOUT_DEFAULT  : default watchdog limit (cycles in WAIT)
// -----------------------------------------------------------------------------
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int MUL_WIDTH_DEFAULT   = 32;
    localparam int MUL_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/seq_mult_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: selects the first set request bit at or
// after the pointer, wrapping around.
// Ports:
//   i_req        in  N_REQ  request vector
//   i_ptr        in  IDW    search start position
//   o_grant_idx  out IDW    index of the selected requester (0 when none)
//   o_any        out 1      at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    output logic [IDW-1:0]   o_grant_idx,
    output logic             o_any
);

    int             w_pos;
    logic [IDW-1:0] w_idx;

    always_comb begin
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_pos       = 0;
        w_idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // position ptr+i folded back into 0..N_REQ-1 (works for non-power-of-2 N_REQ)
            w_pos = int'(i_ptr) + i;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            w_idx = IDW'(w_pos);
            if (!o_any && i_req[w_idx]) begin
                o_any       = 1'b1;
                o_grant_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/seq_mult_arbiter.sv
// -----------------------------------------------------------------------------
// seq_mult_arbiter
// Shares one sequential multiplier among N_REQ requesters. Grants in
// round-robin order, issues a start pulse, waits for completion under a
// watchdog and returns the product over a held response handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for any request; winner operands latched on grant
//   ISSUE | req_ready/mul_start high for one cycle, watchdog cleared
//   WAIT  | waiting for mul_done; watchdog expiry produces error response
//   RESP  | response held until rsp_ready, then pointer advances
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_req_valid/i_req_a/i_req_b    packed requests (slice i = requester i)
//   o_req_ready                    one-hot accept pulse
//   o_rsp_valid/o_rsp_id/
//   o_rsp_product/o_rsp_err        response, held until i_rsp_ready
//   i_rsp_ready                    consumer accepts response
//   o_mul_start/o_mul_a/o_mul_b    multiplier launch
//   o_mul_flush                    multiplier abort pulse on timeout
//   i_mul_done/i_mul_product       multiplier completion
// -----------------------------------------------------------------------------
module seq_mult_arbiter
    import seq_mult_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = MUL_WIDTH_DEFAULT,
    parameter int TIMEOUT = MUL_TIMEOUT_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*WIDTH-1:0]     i_req_a,
    input  logic [N_REQ*WIDTH-1:0]     i_req_b,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic                       o_rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   o_rsp_id,
    output logic [2*WIDTH-1:0]         o_rsp_product,
    output logic                       o_rsp_err,
    input  logic                       i_rsp_ready,
    output logic                       o_mul_start,
    output logic [WIDTH-1:0]           o_mul_a,
    output logic [WIDTH-1:0]           o_mul_b,
    output logic                       o_mul_flush,
    input  logic                       i_mul_done,
    input  logic [2*WIDTH-1:0]         i_mul_product
);

    localparam int IDW = $clog2(N_REQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    arb_state_t         r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [WDW-1:0]     r_wdog;
    logic [N_REQ-1:0]   r_req_ready;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_product;
    logic               r_rsp_err;
    logic               r_mul_start;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic               r_mul_flush;

    logic [IDW-1:0]     w_grant_idx;
    logic               w_any;
    logic [N_REQ-1:0]   w_grant_onehot;
    logic [WIDTH-1:0]   w_a_arr [N_REQ];
    logic [WIDTH-1:0]   w_b_arr [N_REQ];
    logic [IDW-1:0]     w_ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .i_req       (i_req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_a_arr[g] = i_req_a[g*WIDTH +: WIDTH];
        assign w_b_arr[g] = i_req_b[g*WIDTH +: WIDTH];
    end

    always_comb begin
        w_grant_onehot              = '0;
        w_grant_onehot[w_grant_idx] = 1'b1;
    end

    // r_rsp_id still names the last winner while in RESP
    assign w_ptr_next = (r_rsp_id == IDW'(N_REQ - 1)) ? '0 : r_rsp_id + IDW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_wdog        <= '0;
            r_req_ready   <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b0;
            r_mul_start   <= 1'b0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_mul_flush   <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_mul_start <= 1'b0;
            r_mul_flush <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_mul_a     <= w_a_arr[w_grant_idx];
                        r_mul_b     <= w_b_arr[w_grant_idx];
                        r_rsp_id    <= w_grant_idx;
                        r_req_ready <= w_grant_onehot;
                        r_mul_start <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // completion takes priority over a simultaneous watchdog expiry
                    if (i_mul_done) begin
                        r_rsp_product <= i_mul_product;
                        r_rsp_err     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (r_wdog == WDW'(TIMEOUT)) begin
                        r_rsp_product <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_mul_flush   <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_wdog <= r_wdog + WDW'(1);
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= w_ptr_next;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_id      = r_rsp_id;
    assign o_rsp_product = r_rsp_product;
    assign o_rsp_err     = r_rsp_err;
    assign o_mul_start   = r_mul_start;
    assign o_mul_a       = r_mul_a;
    assign o_mul_b       = r_mul_b;
    assign o_mul_flush   = r_mul_flush;

endmodule

// File: tb/tb_seq_mult_arbiter.sv
module tb_seq_mult_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 255;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   o_req_ready;
    logic           o_rsp_valid;
    logic [1:0]     o_rsp_id;
    logic [2*W-1:0] o_rsp_product;
    logic           o_rsp_err;
    logic           rsp_ready;
    logic           o_mul_start;
    logic [W-1:0]   o_mul_a;
    logic [W-1:0]   o_mul_b;
    logic           o_mul_flush;
    logic           mul_done;
    logic [2*W-1:0] mul_product;

    logic [W-1:0]   op_a [N];
    logic [W-1:0]   op_b [N];

    int n_pass;
    int n_total;

    // multiplier mock controls
    int           mock_lat;
    int           mock_cnt;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    int           stray_cnt;
    int           stray_seen;

    assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

    seq_mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .i_req_a       (req_a),
        .i_req_b       (req_b),
        .o_req_ready   (o_req_ready),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_id      (o_rsp_id),
        .o_rsp_product (o_rsp_product),
        .o_rsp_err     (o_rsp_err),
        .i_rsp_ready   (rsp_ready),
        .o_mul_start   (o_mul_start),
        .o_mul_a       (o_mul_a),
        .o_mul_b       (o_mul_b),
        .o_mul_flush   (o_mul_flush),
        .i_mul_done    (mul_done),
        .i_mul_product (mul_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier mock: done pulses mock_lat cycles after the start pulse is seen;
    // mock_lat == 0 means it never completes.
    initial begin
        mul_done    = 1'b0;
        mul_product = '0;
        mock_cnt    = 0;
        stray_seen  = 0;
        m_a         = '0;
        m_b         = '0;
        forever begin
            @(posedge clk);
            #1;
            mul_done = 1'b0;
            if (!rst_n) begin
                mock_cnt = 0;
            end else if (o_mul_start) begin
                mock_cnt = mock_lat;
                m_a      = o_mul_a;
                m_b      = o_mul_b;
            end else if (mock_cnt > 0) begin
                mock_cnt = mock_cnt - 1;
                if (mock_cnt == 0) begin
                    mul_done    = 1'b1;
                    mul_product = 64'(m_a) * 64'(m_b);
                end
            end
            if (stray_cnt != stray_seen) begin
                stray_seen  = stray_cnt;
                mul_done    = 1'b1;
                mul_product = 64'hDEAD_BEEF;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        op_a[idx] = a;
        op_b[idx] = b;
    endtask

    // returns number of steps taken until rsp_valid, or -1 on budget expiry
    task automatic wait_rsp(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (o_rsp_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_ready(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (o_req_ready != '0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        n_total++;
        if ({o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_product, o_rsp_err,
             o_mul_start, o_mul_a, o_mul_b, o_mul_flush} !== '0) begin
            $display("FAIL reset_outputs: got ready=%b rsp_valid=%b id=%0d prod=%h err=%b start=%b a=%h b=%h flush=%b expected all 0",
                     o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_product, o_rsp_err,
                     o_mul_start, o_mul_a, o_mul_b, o_mul_flush);
        end else n_pass++;
        rst_n = 1'b1;
        step();
        n_total++;
        if (o_req_ready !== '0 || o_mul_start !== 1'b0) begin
            $display("FAIL reset_idle_no_req: ready=%b start=%b expected 0/0", o_req_ready, o_mul_start);
        end else n_pass++;
    endtask

    task automatic test_single();
        int cyc;
        mock_lat = 100;
        set_req(2, 32'd7, 32'd6);
        req_valid = 4'b0100;
        step();
        n_total++;
        if (o_req_ready !== 4'b0100 || o_mul_start !== 1'b1) begin
            $display("FAIL single_grant: ready=%b start=%b expected 0100/1", o_req_ready, o_mul_start);
        end else n_pass++;
        n_total++;
        if (o_mul_a !== 32'd7 || o_mul_b !== 32'd6) begin
            $display("FAIL single_operands: a=%0d b=%0d expected 7/6", o_mul_a, o_mul_b);
        end else n_pass++;
        req_valid = 4'b0000;
        step();
        n_total++;
        if (o_req_ready !== 4'b0000 || o_mul_start !== 1'b0) begin
            $display("FAIL single_pulse_width: ready=%b start=%b expected 0000/0", o_req_ready, o_mul_start);
        end else n_pass++;
        wait_rsp(200, cyc);
        n_total++;
        if (cyc !== 100) begin
            $display("FAIL single_latency: cycles=%0d expected 100", cyc);
        end else n_pass++;
        n_total++;
        if (o_rsp_id !== 2'd2 || o_rsp_product !== 64'd42 || o_rsp_err !== 1'b0) begin
            $display("FAIL single_rsp: id=%0d prod=%0d err=%b expected 2/42/0", o_rsp_id, o_rsp_product, o_rsp_err);
        end else n_pass++;
        handshake();
        n_total++;
        if (o_rsp_valid !== 1'b0) begin
            $display("FAIL single_rsp_clear: rsp_valid=%b expected 0", o_rsp_valid);
        end else n_pass++;
    endtask

    task automatic test_round_robin();
        int cyc;
        logic [2*W-1:0] exp_prod [N];
        exp_prod[0] = 64'hFFFF_FFFE_0000_0001;
        exp_prod[1] = 64'd15;
        exp_prod[2] = 64'h0000_0001_0000_0000;
        exp_prod[3] = 64'd0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mock_lat = 3;
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set_req(1, 32'd3, 32'd5);
        set_req(2, 32'h0001_0000, 32'h0001_0000);
        set_req(3, 32'd12345, 32'd0);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ready(20, cyc);
            n_total++;
            if (cyc !== 1 || o_req_ready !== (4'b0001 << (k % N))) begin
                $display("FAIL rr_grant_%0d: ready=%b after %0d cycles expected %b after 1",
                         k, o_req_ready, cyc, 4'b0001 << (k % N));
            end else n_pass++;
            wait_rsp(50, cyc);
            n_total++;
            if (cyc < 0 || o_rsp_id !== 2'(k % N) || o_rsp_product !== exp_prod[k % N] || o_rsp_err !== 1'b0) begin
                $display("FAIL rr_rsp_%0d: id=%0d prod=%h err=%b expected %0d/%h/0",
                         k, o_rsp_id, o_rsp_product, o_rsp_err, k % N, exp_prod[k % N]);
            end else n_pass++;
            if (k == 4) req_valid = 4'b0000;
            handshake();
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_stall();
        int cyc;
        int bad;
        mock_lat = 5;
        set_req(1, 32'd9, 32'd11);
        set_req(3, 32'd100, 32'd3);
        req_valid = 4'b1010;
        wait_ready(20, cyc);
        n_total++;
        if (o_req_ready !== 4'b0010) begin
            $display("FAIL stall_grant: ready=%b expected 0010", o_req_ready);
        end else n_pass++;
        req_valid = 4'b1000;
        wait_rsp(50, cyc);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd1 || o_rsp_product !== 64'd99 || o_req_ready !== 4'b0000)
                bad++;
        end
        n_total++;
        if (cyc < 0 || bad !== 0) begin
            $display("FAIL stall_hold: unstable cycles=%0d wait=%0d expected 0 unstable, id=1 prod=99", bad, cyc);
        end else n_pass++;
        handshake();
        n_total++;
        if (o_rsp_valid !== 1'b0) begin
            $display("FAIL stall_release: rsp_valid=%b expected 0", o_rsp_valid);
        end else n_pass++;
        step();
        n_total++;
        if (o_req_ready !== 4'b1000) begin
            $display("FAIL stall_next_grant: ready=%b expected 1000", o_req_ready);
        end else n_pass++;
        req_valid = 4'b0000;
        wait_rsp(50, cyc);
        n_total++;
        if (cyc < 0 || o_rsp_id !== 2'd3 || o_rsp_product !== 64'd300) begin
            $display("FAIL stall_second_rsp: id=%0d prod=%0d expected 3/300", o_rsp_id, o_rsp_product);
        end else n_pass++;
        handshake();
    endtask

    task automatic test_timeout();
        int cyc;
        mock_lat = 0;
        set_req(0, 32'd5, 32'd5);
        req_valid = 4'b0001;
        step();
        n_total++;
        if (o_req_ready !== 4'b0001) begin
            $display("FAIL timeout_grant: ready=%b expected 0001", o_req_ready);
        end else n_pass++;
        req_valid = 4'b0000;
        wait_rsp(400, cyc);
        n_total++;
        if (cyc !== TO + 2) begin
            $display("FAIL timeout_latency: cycles=%0d expected %0d", cyc, TO + 2);
        end else n_pass++;
        n_total++;
        if (o_rsp_err !== 1'b1 || o_rsp_product !== 64'd0 || o_mul_flush !== 1'b1 || o_rsp_id !== 2'd0) begin
            $display("FAIL timeout_rsp: err=%b prod=%h flush=%b id=%0d expected 1/0/1/0",
                     o_rsp_err, o_rsp_product, o_mul_flush, o_rsp_id);
        end else n_pass++;
        step();
        n_total++;
        if (o_mul_flush !== 1'b0 || o_rsp_valid !== 1'b1) begin
            $display("FAIL timeout_flush_pulse: flush=%b rsp_valid=%b expected 0/1", o_mul_flush, o_rsp_valid);
        end else n_pass++;
        handshake();
        stray_cnt++;
        step();
        step();
        step();
        n_total++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 4'b0000 || o_mul_start !== 1'b0) begin
            $display("FAIL stray_done_idle: rsp_valid=%b ready=%b start=%b expected 0/0000/0",
                     o_rsp_valid, o_req_ready, o_mul_start);
        end else n_pass++;
    endtask

    task automatic test_done_at_timeout();
        int cyc;
        mock_lat = TO + 1;
        set_req(1, 32'd6, 32'd7);
        req_valid = 4'b0010;
        step();
        n_total++;
        if (o_req_ready !== 4'b0010) begin
            $display("FAIL collide_grant: ready=%b expected 0010", o_req_ready);
        end else n_pass++;
        req_valid = 4'b0000;
        wait_rsp(400, cyc);
        n_total++;
        if (cyc !== TO + 2 || o_rsp_err !== 1'b0 || o_rsp_product !== 64'd42 || o_mul_flush !== 1'b0) begin
            $display("FAIL collide_rsp: cycles=%0d err=%b prod=%0d flush=%b expected %0d/0/42/0",
                     cyc, o_rsp_err, o_rsp_product, o_mul_flush, TO + 2);
        end else n_pass++;
        handshake();
    endtask

    task automatic test_async_reset();
        int cyc;
        mock_lat = 100;
        set_req(2, 32'd3, 32'd3);
        req_valid = 4'b0100;
        step();
        n_total++;
        if (o_req_ready !== 4'b0100) begin
            $display("FAIL areset_pre_grant: ready=%b expected 0100", o_req_ready);
        end else n_pass++;
        req_valid = 4'b0000;
        repeat (10) step();
        #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_product, o_rsp_err,
             o_mul_start, o_mul_a, o_mul_b, o_mul_flush} !== '0) begin
            $display("FAIL areset_outputs: ready=%b rsp_valid=%b id=%0d prod=%h err=%b start=%b a=%h b=%h flush=%b expected all 0",
                     o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_product, o_rsp_err,
                     o_mul_start, o_mul_a, o_mul_b, o_mul_flush);
        end else n_pass++;
        step();
        #2;
        rst_n = 1'b1;
        set_req(3, 32'd4, 32'd5);
        req_valid = 4'b1000;
        step();
        n_total++;
        if (o_req_ready !== 4'b1000) begin
            $display("FAIL areset_grant3: ready=%b expected 1000", o_req_ready);
        end else n_pass++;
        req_valid = 4'b0000;
        wait_rsp(200, cyc);
        n_total++;
        if (cyc < 0 || o_rsp_id !== 2'd3 || o_rsp_product !== 64'd20 || o_rsp_err !== 1'b0) begin
            $display("FAIL areset_rsp: id=%0d prod=%0d err=%b expected 3/20/0", o_rsp_id, o_rsp_product, o_rsp_err);
        end else n_pass++;
        handshake();
        set_req(0, 32'd2, 32'd2);
        req_valid = 4'b1001;
        step();
        n_total++;
        if (o_req_ready !== 4'b0001) begin
            $display("FAIL ptr_wrap: ready=%b expected 0001", o_req_ready);
        end else n_pass++;
        req_valid = 4'b0000;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        mock_lat  = 0;
        stray_cnt = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_timeout();
        test_done_at_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
